// File: rtl/fifo_win_sum.sv
// Streaming vertical-window summer: per column, sums the current element with the
// WIN-1 vertically aligned elements of the preceding rows held in circular line buffers.
module fifo_win_sum #(
  parameter int DATA_W  = 8,
  parameter int COL_NUM = 50,
  parameter int ROW_NUM = 50,
  parameter int WIN     = 3,
  parameter int SUM_W   = DATA_W + 3
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              clr,
  input  logic [DATA_W-1:0] pi_data,
  input  logic              pi_flag,
  output logic [SUM_W-1:0]  po_sum,
  output logic              po_flag,
  output logic              frame_done
);

  localparam int CW = $clog2(COL_NUM);
  localparam int RW = $clog2(ROW_NUM);
  localparam int NB = WIN - 1;

  localparam logic [CW-1:0] COL_LAST  = CW'(COL_NUM - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(ROW_NUM - 1);
  localparam logic [RW-1:0] ROW_FIRST = RW'(WIN - 1);

  function automatic logic [SUM_W-1:0] widen(input logic [DATA_W-1:0] d);
    return SUM_W'(d);
  endfunction

  logic [CW-1:0]     col_cnt;
  logic [RW-1:0]     row_cnt;
  logic              accept_p0;
  logic              col_wrap_p0;
  logic              row_wrap_p0;
  logic              vld_p0;
  logic [SUM_W-1:0]  sum_p0;
  logic [DATA_W-1:0] lb_rd_p0 [NB];
  logic [DATA_W-1:0] lb       [NB][COL_NUM];

  // ---- stage p0: address the line buffers with col_cnt and form the window sum
  // An element arriving together with clr is dropped entirely.
  assign accept_p0   = pi_flag & ~clr;
  assign col_wrap_p0 = (col_cnt == COL_LAST);
  assign row_wrap_p0 = (row_cnt == ROW_LAST);
  assign vld_p0      = accept_p0 && (row_cnt >= ROW_FIRST);

  always_comb begin
    for (int k = 0; k < NB; k++) lb_rd_p0[k] = lb[k][col_cnt];
  end

  always_comb begin
    sum_p0 = widen(pi_data);
    for (int k = 0; k < NB; k++) sum_p0 = sum_p0 + widen(lb_rd_p0[k]);
  end

  // Rows shift one buffer down the chain; the oldest row falls off the end.
  always_ff @(posedge sys_clk) begin
    if (accept_p0) begin
      lb[0][col_cnt] <= pi_data;
      for (int k = 1; k < NB; k++) lb[k][col_cnt] <= lb_rd_p0[k-1];
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      col_cnt <= '0;
      row_cnt <= '0;
    end else if (clr) begin
      col_cnt <= '0;
      row_cnt <= '0;
    end else if (accept_p0) begin
      col_cnt <= col_wrap_p0 ? '0 : col_cnt + 1'b1;
      if (col_wrap_p0) row_cnt <= row_wrap_p0 ? '0 : row_cnt + 1'b1;
    end
  end

  // ---- stage p1: registered outputs, po_sum held between strobes
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      po_sum     <= '0;
      po_flag    <= 1'b0;
      frame_done <= 1'b0;
    end else if (clr) begin
      po_sum     <= '0;
      po_flag    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      po_flag    <= vld_p0;
      frame_done <= vld_p0 & col_wrap_p0 & row_wrap_p0;
      if (vld_p0) po_sum <= sum_p0;
    end
  end

endmodule

// File: tb/tb_fifo_win_sum.sv
// Scoreboard bench for fifo_win_sum: a 4x4 WIN=3 instance for the main scenarios
// and a 4x8 WIN=8 instance for the full-scale overflow boundary.
module tb_fifo_win_sum;

  typedef struct {
    longint sum;
    bit     done;
    longint cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        clr = 1'b0;
  logic [7:0]  pi_data = '0;
  logic        pi_flag = 1'b0;
  logic [10:0] po_sum;
  logic        po_flag;
  logic        frame_done;

  logic        clr2 = 1'b0;
  logic [7:0]  pi_data2 = '0;
  logic        pi_flag2 = 1'b0;
  logic [10:0] po_sum2;
  logic        po_flag2;
  logic        frame_done2;

  exp_t   q1[$];
  exp_t   q2[$];
  longint cyc = 0;
  int     n_cmp = 0;
  int     n_fail = 0;
  bit     check_hold = 1'b0;
  longint hold_exp = 0;

  // Hand-computed rows 2 and 3 for a 1..16 frame and for the 101..116 frame.
  int exp0   [8] = '{15, 18, 21, 24, 27, 30, 33, 36};
  int exp100 [8] = '{315, 318, 321, 324, 327, 330, 333, 336};

  fifo_win_sum #(.DATA_W(8), .COL_NUM(4), .ROW_NUM(4), .WIN(3), .SUM_W(11)) dut (
    .sys_clk(clk), .sys_rst_n(rst_n), .clr(clr), .pi_data(pi_data), .pi_flag(pi_flag),
    .po_sum(po_sum), .po_flag(po_flag), .frame_done(frame_done)
  );

  fifo_win_sum #(.DATA_W(8), .COL_NUM(4), .ROW_NUM(8), .WIN(8), .SUM_W(11)) dut8 (
    .sys_clk(clk), .sys_rst_n(rst_n), .clr(clr2), .pi_data(pi_data2), .pi_flag(pi_flag2),
    .po_sum(po_sum2), .po_flag(po_flag2), .frame_done(frame_done2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint req);
    n_cmp++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      chk("rst_po_flag", po_flag, 0);
      chk("rst_frame_done", frame_done, 0);
      chk("rst_po_sum", po_sum, 0);
    end else if (po_flag) begin
      if (q1.size() == 0) chk("spurious_po_flag", po_flag, 0);
      else begin
        e = q1.pop_front();
        chk("po_sum", po_sum, e.sum);
        chk("frame_done", frame_done, e.done);
        chk("latency_cycle", cyc, e.cyc);
        hold_exp = e.sum;
      end
    end else begin
      chk("stray_frame_done", frame_done, 0);
      if (check_hold) chk("po_sum_hold", po_sum, hold_exp);
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      chk("rst_po_flag_w8", po_flag2, 0);
      chk("rst_po_sum_w8", po_sum2, 0);
    end else if (po_flag2) begin
      if (q2.size() == 0) chk("spurious_po_flag_w8", po_flag2, 0);
      else begin
        e = q2.pop_front();
        chk("po_sum_w8", po_sum2, e.sum);
        chk("frame_done_w8", frame_done2, e.done);
        chk("latency_cycle_w8", cyc, e.cyc);
      end
    end else begin
      chk("stray_frame_done_w8", frame_done2, 0);
    end
  end

  // Called at 1 time unit after a rising edge; leaves at the same phase.
  task automatic send(input int d, input int gap, input bit has_exp, input int es, input bit ed);
    pi_data = 8'(d);
    pi_flag = 1'b1;
    if (has_exp) q1.push_back('{longint'(es), ed, cyc + 1});
    @(posedge clk); #1;
    pi_flag = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic send_frame(input int base, input int maxgap, input int n);
    int es;
    for (int i = 0; i < n; i++) begin
      es = (i >= 8) ? ((base == 0) ? exp0[i-8] : exp100[i-8]) : 0;
      send(base + i + 1, (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0,
           i >= 8, es, i == 15);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(1);

    // consecutive 1..16 frame
    send_frame(0, 0, 16);
    idle(2);

    // same frame with random gaps; po_sum must hold between strobes
    check_hold = 1'b1;
    send_frame(0, 7, 16);
    idle(2);
    check_hold = 1'b0;

    // two frames back to back, second offset by 100
    send_frame(0, 0, 16);
    send_frame(100, 0, 16);
    idle(2);

    // reset asserted midway through row 2, then a fresh frame
    send_frame(0, 0, 10);
    idle(1);
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(1);
    send_frame(0, 0, 16);
    idle(2);

    // clr colliding with an element in row 1, then a fresh frame
    send_frame(0, 0, 5);
    clr = 1'b1;
    pi_data = 8'd6;
    pi_flag = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    pi_flag = 1'b0;
    chk("clr_po_flag", po_flag, 0);
    chk("clr_frame_done", frame_done, 0);
    idle(1);
    send_frame(0, 0, 16);
    idle(2);

    // WIN=8 full-scale inputs: 8 x 0xFF = 2040 without truncation
    for (int i = 0; i < 32; i++) begin
      pi_data2 = 8'hFF;
      pi_flag2 = 1'b1;
      if (i >= 28) q2.push_back('{longint'(2040), i == 31, cyc + 1});
      @(posedge clk); #1;
      pi_flag2 = 1'b0;
    end
    idle(4);

    chk("queue_drained", q1.size(), 0);
    chk("queue_drained_w8", q2.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
